ddd_vertex_feeder: RTL and testbench
====================================

// Module: ddd_vertex_feeder
// PURPOSE
// Producer end of the projector's vertex-stream interface. Accepts whole world-space triangles
// over a valid/ready handshake, subtracts the camera position, and culls triangles the projector
// cannot divide safely. Serializes each survivor as 3 consecutive vertices with a new_triangle
// strobe, and ends each frame with a single done strobe. Sits between scene/obstacle generation
// and ddd_projector.
// PARAMETERS
// LOG_Z0    7   projection-plane shift used by the projector; sets the x/y magnitude limit 2^(16-LOG_Z0)
// Z_NEAR    16  minimum camera-space z (signed 16b); triangles with any vertex z < Z_NEAR are culled
// CNT_W     16  width of per-frame statistics counters
// PORTS
// clk              in   1     system clock
// rst_n            in   1     asynchronous, active-low reset
// tri_valid        in   1     upstream triangle valid
// tri_ready        out  1     feeder can accept a triangle this cycle
// tri_data         in   160   {color[15:0], v1[47:0], v2[47:0], v3[47:0]}; vertex = {x,y,z}, each signed 16b
// tri_last         in   1     qualifies tri_data: last triangle of frame
// cam_pos          in   48    camera {x,y,z}, signed 16b each; sampled on the first accept of a frame
// vertex           out  48    camera-space vertex to projector
// color            out  16    triangle color, held for all 3 vertex cycles
// new_triangle_out out  1     high with the first vertex of each emitted triangle
// done_out         out  1     one-cycle frame-end strobe
// emitted_cnt      out  CNT_W triangles emitted this frame
// culled_cnt       out  CNT_W triangles culled this frame
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE; vertex, color, new_triangle_out, done_out = 0;
//   counters = 0; in_frame = 0; tri_ready = 0 while rst_n is low.
// - Accept occurs when tri_valid && tri_ready. tri_ready = 1 in IDLE and V3, and 0 in V1, V2, DONE.
// - On accept: latch cam_pos if !in_frame, then set in_frame. Compute 17b signed differences v - cam.
//   Cull when any diff z < Z_NEAR, or |diff x| or |diff y| >= 2^(16-LOG_Z0), or any diff overflows
//   16b signed. The registered result is {3 translated vertices, color, cull, last}.
// - On the first accept of a frame, zero both counters in the same cycle; the new triangle's own
//   increment still applies, so the count starts at 1.
// - FSM IDLE -> V1 -> V2 -> V3, then -> V1 | DONE | IDLE:
//   IDLE: accept non-culled -> V1. Accept culled -> culled_cnt++; if last -> DONE, else stay IDLE.
//   V1: vertex = v1, new_triangle_out = 1 -> V2.  V2: vertex = v2 -> V3.
//   V3: vertex = v3. Then:
//     - if the current triangle is last -> DONE (tri_ready forced 0);
//     - else if a non-culled accept occurs -> V1 (back-to-back, 3 cycles/triangle);
//     - else if a culled accept occurs -> culled_cnt++; if that triangle is last -> DONE, else IDLE;
//     - else -> IDLE.
//   DONE: done_out = 1 for one cycle, clear in_frame -> IDLE.
// - emitted_cnt increments on entry to V1. Counters saturate at all-ones and hold until the next frame.
// - color is valid on the V1 cycle and held through V3. Outside V1..V3, vertex and color = 0.
// - All outputs are registered: a triangle accepted at cycle t appears as V1 at t+1.
// - done_out always follows the last triangle's V3 by exactly 1 cycle; the projector's equal
//   pipeline depth then keeps done after the final triangle.
// - A frame whose triangles are all culled still produces exactly one done_out.
// - Reset mid-triangle or mid-frame aborts silently: no partial vertices and no done_out.
// STRUCTURE
// - ddd_pkg: vertex_t (packed signed x,y,z), tri_in_t (160b layout above), feeder_state_e,
//   and field-offset localparams for the tri_data unpack.
// - Sub-module ddd_translate_cull: combinational camera subtract plus cull test for one triangle;
//   the feeder registers its outputs.
// TESTING
// 1) Single tri, cam = 0, v = (10,20,100),(-5,0,200),(0,-30,64), last=1 ->
//    V1..V3 at t+1..t+3, new_triangle only at t+1, done_out at t+4, emitted = 1.
// 2) 4 back-to-back valid tris, last on #4 -> 12 contiguous vertex cycles,
//    new_triangle at t+1, t+4, t+7, t+10; one done_out; emitted = 4.
// 3) cam = (0,0,50), tri with a vertex z = 60 (diff 10 < 16) among 2 good ones ->
//    culled = 1, emitted = 2, no vertex gap larger than 1 idle.
// 4) Culled tri with last=1, and no survivors in frame -> no new_triangle, one done_out, culled = 1.
// 5) Overflow: x = 32767 with cam x = -10, and |x| = 512 boundary (511 passes, 512 culled).
// 6) rst_n low during V2 -> outputs 0 immediately, no done_out; the next frame restarts counters.

Source files
------------

// File: rtl/ddd_pkg.sv
// Shared types and field layout for the vertex-stream producer.
package ddd_pkg;

  localparam int unsigned COORD_W   = 16;
  localparam int unsigned VTX_W     = 3 * COORD_W;
  localparam int unsigned COLOR_W   = 16;
  localparam int unsigned TRI_W     = COLOR_W + 3 * VTX_W;

  // Bit offsets of each field inside the 160b triangle word
  localparam int unsigned COLOR_LSB = 3 * VTX_W;
  localparam int unsigned V1_LSB    = 2 * VTX_W;
  localparam int unsigned V2_LSB    = VTX_W;
  localparam int unsigned V3_LSB    = 0;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
    logic signed [COORD_W-1:0] z;
  } vertex_t;

  typedef struct packed {
    logic [COLOR_W-1:0] color;
    vertex_t            v1;
    vertex_t            v2;
    vertex_t            v3;
  } tri_in_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_V1   = 3'd1,
    ST_V2   = 3'd2,
    ST_V3   = 3'd3,
    ST_DONE = 3'd4
  } feeder_state_e;

endpackage

// File: rtl/ddd_translate_cull.sv
// Camera subtract for one triangle plus the "projector can divide it" test.
module ddd_translate_cull
  import ddd_pkg::*;
#(
  parameter int unsigned LOG_Z0 = 7,
  parameter int          Z_NEAR = 16
) (
  input  tri_in_t tri_in,
  input  vertex_t cam,
  output vertex_t v1,
  output vertex_t v2,
  output vertex_t v3,
  output logic    cull
);

  localparam logic signed [COORD_W:0] LIM  = (COORD_W+1)'(1 << (16 - LOG_Z0));
  localparam logic signed [COORD_W:0] ZMIN = (COORD_W+1)'(Z_NEAR);

  // Returns {cull, translated vertex}; diffs kept at 17b so overflow is exact
  function automatic logic [VTX_W:0] xlate(input vertex_t v, input vertex_t c);
    logic signed [COORD_W:0] dx, dy, dz;
    logic bad;
    dx  = $signed({v.x[COORD_W-1], v.x}) - $signed({c.x[COORD_W-1], c.x});
    dy  = $signed({v.y[COORD_W-1], v.y}) - $signed({c.y[COORD_W-1], c.y});
    dz  = $signed({v.z[COORD_W-1], v.z}) - $signed({c.z[COORD_W-1], c.z});
    bad = (dx[COORD_W] ^ dx[COORD_W-1]) | (dy[COORD_W] ^ dy[COORD_W-1]) |
          (dz[COORD_W] ^ dz[COORD_W-1]) |
          (dx >= LIM) | (dx <= -LIM) | (dy >= LIM) | (dy <= -LIM) |
          (dz < ZMIN);
    return {bad, dx[COORD_W-1:0], dy[COORD_W-1:0], dz[COORD_W-1:0]};
  endfunction

  logic c1, c2, c3;

  // Translate all three vertices; any single bad vertex culls the triangle
  always_comb begin
    {c1, v1} = xlate(tri_in.v1, cam);
    {c2, v2} = xlate(tri_in.v2, cam);
    {c3, v3} = xlate(tri_in.v3, cam);
    cull     = c1 | c2 | c3;
  end

endmodule

// File: rtl/ddd_vertex_feeder.sv
// Triangle-to-vertex serializer feeding the projector, with culling and frame stats.
module ddd_vertex_feeder
  import ddd_pkg::*;
#(
  parameter int unsigned LOG_Z0 = 7,
  parameter int          Z_NEAR = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tri_valid,
  output logic               tri_ready,
  input  logic [TRI_W-1:0]   tri_data,
  input  logic               tri_last,
  input  logic [VTX_W-1:0]   cam_pos,
  output logic [VTX_W-1:0]   vertex,
  output logic [COLOR_W-1:0] color,
  output logic               new_triangle_out,
  output logic               done_out,
  output logic [CNT_W-1:0]   emitted_cnt,
  output logic [CNT_W-1:0]   culled_cnt
);

  feeder_state_e state, state_nxt;

  tri_in_t tri_in;
  vertex_t cam_reg, cam_eff;
  vertex_t t1, t2, t3;
  logic    cull;
  vertex_t cur_v2, cur_v3;
  logic    cur_last;
  logic    in_frame;
  logic    accept, first;

  logic [VTX_W-1:0]   vertex_nxt;
  logic [COLOR_W-1:0] color_nxt;
  logic               new_nxt, done_nxt, ready_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign tri_in = tri_in_t'({tri_data[COLOR_LSB +: COLOR_W], tri_data[V1_LSB +: VTX_W],
                             tri_data[V2_LSB +: VTX_W], tri_data[V3_LSB +: VTX_W]});

  // Camera is taken live on the opening accept of a frame, latched afterwards
  assign cam_eff = in_frame ? cam_reg : vertex_t'(cam_pos);
  assign accept  = tri_valid & tri_ready;
  assign first   = accept & ~in_frame;

  ddd_translate_cull #(
    .LOG_Z0 (LOG_Z0),
    .Z_NEAR (Z_NEAR)
  ) u_xlate (
    .tri_in (tri_in),
    .cam    (cam_eff),
    .v1     (t1),
    .v2     (t2),
    .v3     (t3),
    .cull   (cull)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: V3 behaves like IDLE for a new accept unless it closes the frame
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_V3: begin
        if (state == ST_V3 && cur_last) state_nxt = ST_DONE;
        else if (accept)                state_nxt = cull ? (tri_last ? ST_DONE : ST_IDLE) : ST_V1;
        else                            state_nxt = ST_IDLE;
      end
      ST_V1:   state_nxt = ST_V2;
      ST_V2:   state_nxt = ST_V3;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered below
  always_comb begin
    vertex_nxt = '0;
    color_nxt  = '0;
    new_nxt    = 1'b0;
    done_nxt   = 1'b0;
    ready_nxt  = 1'b0;
    case (state_nxt)
      ST_IDLE: ready_nxt = 1'b1;
      ST_V1: begin
        vertex_nxt = t1;
        color_nxt  = tri_in.color;
        new_nxt    = 1'b1;
      end
      ST_V2: begin
        vertex_nxt = cur_v2;
        color_nxt  = color;
      end
      ST_V3: begin
        vertex_nxt = cur_v3;
        color_nxt  = color;
        ready_nxt  = ~cur_last;
      end
      ST_DONE: done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Registered outputs toward the projector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vertex           <= '0;
      color            <= '0;
      new_triangle_out <= 1'b0;
      done_out         <= 1'b0;
      tri_ready        <= 1'b0;
    end else begin
      vertex           <= vertex_nxt;
      color            <= color_nxt;
      new_triangle_out <= new_nxt;
      done_out         <= done_nxt;
      tri_ready        <= ready_nxt;
    end
  end

  // Accepted-triangle hold, frame camera and per-frame saturating statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cam_reg     <= '0;
      cur_v2      <= '0;
      cur_v3      <= '0;
      cur_last    <= 1'b0;
      in_frame    <= 1'b0;
      emitted_cnt <= '0;
      culled_cnt  <= '0;
    end else begin
      if (first) cam_reg <= vertex_t'(cam_pos);
      if (accept) begin
        cur_v2   <= t2;
        cur_v3   <= t3;
        cur_last <= tri_last;
      end
      if (state == ST_DONE) in_frame <= 1'b0;
      else if (accept)      in_frame <= 1'b1;
      if (accept && !cull)  emitted_cnt <= first ? CNT_W'(1) : sat_inc(emitted_cnt);
      else if (first)       emitted_cnt <= '0;
      if (accept && cull)   culled_cnt  <= first ? CNT_W'(1) : sat_inc(culled_cnt);
      else if (first)       culled_cnt  <= '0;
    end
  end

endmodule

// File: tb/tb_ddd_vertex_feeder.sv
// Randomized + directed bench for ddd_vertex_feeder against a cycle-timeline reference model.
module tb_ddd_vertex_feeder;
  import ddd_pkg::*;

  localparam int LIM = 1 << (16 - 7);
  localparam int ZN  = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               tri_valid = 1'b0;
  logic               tri_ready;
  logic [TRI_W-1:0]   tri_data = '0;
  logic               tri_last = 1'b0;
  logic [VTX_W-1:0]   cam_pos = '0;
  logic [VTX_W-1:0]   vertex;
  logic [COLOR_W-1:0] color;
  logic               new_triangle_out, done_out;
  logic [15:0]        emitted_cnt, culled_cnt;

  ddd_vertex_feeder #(.LOG_Z0(7), .Z_NEAR(16), .CNT_W(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tri_valid        (tri_valid),
    .tri_ready        (tri_ready),
    .tri_data         (tri_data),
    .tri_last         (tri_last),
    .cam_pos          (cam_pos),
    .vertex           (vertex),
    .color            (color),
    .new_triangle_out (new_triangle_out),
    .done_out         (done_out),
    .emitted_cnt      (emitted_cnt),
    .culled_cnt       (culled_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { tri_in_t t; logic last; vertex_t cam; } item_t;
  typedef struct { vertex_t v; logic [15:0] col; bit nt; bit dn; int em; int cu; } beat_t;

  item_t  send_q[$];
  item_t  cur;
  beat_t  exp_beat[int];
  bit     blocked[int];
  int     cyc = 0, total = 0, bad = 0;
  int     busy_until = 0, last_acc = -100, gap_pct = 0;
  bit     in_frame = 0;
  vertex_t cam_m;
  int     em_m = 0, cu_m = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic vertex_t vtx(input int x, input int y, input int z);
    vertex_t v;
    v.x = 16'(x); v.y = 16'(y); v.z = 16'(z);
    return v;
  endfunction

  // Reference: plain-integer camera subtract and cull rule
  function automatic bit ref_xlate(input vertex_t v, input vertex_t c, output vertex_t o);
    int d[3];
    bit b = 0;
    d[0] = int'($signed(v.x)) - int'($signed(c.x));
    d[1] = int'($signed(v.y)) - int'($signed(c.y));
    d[2] = int'($signed(v.z)) - int'($signed(c.z));
    for (int i = 0; i < 3; i++) if (d[i] > 32767 || d[i] < -32768) b = 1;
    for (int i = 0; i < 2; i++) if (d[i] >= LIM || d[i] <= -LIM) b = 1;
    if (d[2] < ZN) b = 1;
    o = vtx(d[0], d[1], d[2]);
    return b;
  endfunction

  // Decide whether this cycle accepts, and schedule the resulting output timeline
  function automatic bit model_accept();
    vertex_t o1, o2, o3;
    bit c1, c2, c3;
    if (!tri_valid || blocked.exists(cyc)) return 0;
    if (!in_frame) begin cam_m = cur.cam; in_frame = 1; em_m = 0; cu_m = 0; end
    c1 = ref_xlate(cur.t.v1, cam_m, o1);
    c2 = ref_xlate(cur.t.v2, cam_m, o2);
    c3 = ref_xlate(cur.t.v3, cam_m, o3);
    last_acc = cyc;
    if (!(c1 | c2 | c3)) begin
      if (em_m < 65535) em_m++;
      exp_beat[cyc+1] = '{v:o1, col:cur.t.color, nt:1, dn:0, em:0, cu:0};
      exp_beat[cyc+2] = '{v:o2, col:cur.t.color, nt:0, dn:0, em:0, cu:0};
      exp_beat[cyc+3] = '{v:o3, col:cur.t.color, nt:0, dn:0, em:0, cu:0};
      blocked[cyc+1] = 1; blocked[cyc+2] = 1;
      busy_until = cyc + 3;
      if (cur.last) begin
        blocked[cyc+3] = 1; blocked[cyc+4] = 1;
        exp_beat[cyc+4] = '{v:'0, col:'0, nt:0, dn:1, em:em_m, cu:cu_m};
        busy_until = cyc + 4;
        in_frame = 0;
      end
    end else begin
      if (cu_m < 65535) cu_m++;
      if (cur.last) begin
        blocked[cyc+1] = 1;
        exp_beat[cyc+1] = '{v:'0, col:'0, nt:0, dn:1, em:em_m, cu:cu_m};
        if (busy_until < cyc + 1) busy_until = cyc + 1;
        in_frame = 0;
      end
    end
    return 1;
  endfunction

  task automatic check_cycle();
    beat_t e;
    e = '{v:'0, col:'0, nt:0, dn:0, em:0, cu:0};
    if (exp_beat.exists(cyc)) e = exp_beat[cyc];
    check("vertex", 64'(vertex), 64'(e.v));
    check("color", 64'(color), 64'(e.col));
    check("new_tri", 64'(new_triangle_out), 64'(e.nt));
    check("done", 64'(done_out), 64'(e.dn));
    check("ready", 64'(tri_ready), 64'(!blocked.exists(cyc)));
    if (e.dn) begin
      check("emitted", 64'(emitted_cnt), 64'(e.em));
      check("culled", 64'(culled_cnt), 64'(e.cu));
    end
  endtask

  task automatic step();
    bit acc;
    @(negedge clk);
    check_cycle();
    acc = model_accept();
    @(posedge clk);
    cyc++;
    #1;
    if (acc) tri_valid = 1'b0;
    if (!tri_valid) begin
      if (send_q.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
        cur       = send_q.pop_front();
        tri_valid = 1'b1;
        tri_data  = cur.t;
        tri_last  = cur.last;
        cam_pos   = cur.cam;
      end else begin
        tri_data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        tri_last = 1'($urandom_range(1));
        cam_pos  = {$urandom(), 16'($urandom())};
      end
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((send_q.size() > 0 || tri_valid || busy_until >= cyc) && guard < 5000) begin
      step();
      guard++;
    end
    if (guard >= 5000) check("drain_timeout", 64'(1), 64'(0));
    repeat (3) step();
  endtask

  task automatic push(input vertex_t a, input vertex_t b, input vertex_t c,
                      input int col, input bit last, input vertex_t cam);
    item_t it;
    it.t.color = 16'(col);
    it.t.v1 = a; it.t.v2 = b; it.t.v3 = c;
    it.last = last;
    it.cam  = cam;
    send_q.push_back(it);
  endtask

  function automatic vertex_t rnd_v();
    int x, y, z;
    x = int'($urandom_range(1200)) - 600;
    y = int'($urandom_range(1200)) - 600;
    z = int'($urandom_range(400)) - 40;
    if ($urandom_range(19) == 0) x = 32767 - int'($urandom_range(3));
    if ($urandom_range(19) == 0) z = -32768 + int'($urandom_range(3));
    return vtx(x, y, z);
  endfunction

  function automatic vertex_t rnd_cam();
    vertex_t c;
    c = vtx(int'($urandom_range(200)) - 100, int'($urandom_range(200)) - 100,
            int'($urandom_range(60)) - 30);
    if ($urandom_range(9) == 0) c.x = 16'(-32768 + int'($urandom_range(20)));
    return c;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state while rst_n is held low
    #12;
    check("rst_vertex", 64'(vertex), 64'(0));
    check("rst_color", 64'(color), 64'(0));
    check("rst_new", 64'(new_triangle_out), 64'(0));
    check("rst_done", 64'(done_out), 64'(0));
    check("rst_ready", 64'(tri_ready), 64'(0));
    check("rst_emitted", 64'(emitted_cnt), 64'(0));
    check("rst_culled", 64'(culled_cnt), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single triangle at camera origin
    gap_pct = 0;
    push(vtx(10, 20, 100), vtx(-5, 0, 200), vtx(0, -30, 64), 16'h1234, 1, vtx(0, 0, 0));
    drain();

    // Four back-to-back survivors
    for (int k = 0; k < 4; k++)
      push(vtx(k, 1, 50 + k), vtx(-k, 2, 60), vtx(3, -k, 70), 16'h0a00 + k, k == 3, vtx(0, 0, 0));
    drain();

    // Near-plane cull sandwiched between two survivors
    push(vtx(1, 1, 100), vtx(2, 2, 100), vtx(3, 3, 100), 16'h00b1, 0, vtx(0, 0, 50));
    push(vtx(1, 1, 100), vtx(2, 2, 60), vtx(3, 3, 100), 16'h00b2, 0, vtx(0, 0, 50));
    push(vtx(4, 4, 66), vtx(5, 5, 100), vtx(6, 6, 100), 16'h00b3, 1, vtx(0, 0, 50));
    drain();

    // Frame of a single culled last triangle
    push(vtx(0, 0, 5), vtx(0, 0, 100), vtx(0, 0, 100), 16'h00c1, 1, vtx(0, 0, 0));
    drain();

    // Overflow of x - cam.x, then the +/-512 magnitude boundary
    push(vtx(32767, 0, 100), vtx(0, 0, 100), vtx(0, 0, 100), 16'h00d1, 1, vtx(-10, 0, 0));
    push(vtx(511, 0, 100), vtx(0, 511, 100), vtx(-511, 0, 100), 16'h00d2, 0, vtx(0, 0, 0));
    push(vtx(512, 0, 100), vtx(0, 0, 100), vtx(0, 0, 100), 16'h00d3, 0, vtx(0, 0, 0));
    push(vtx(0, -511, 100), vtx(0, 0, 16), vtx(0, 0, 100), 16'h00d4, 0, vtx(0, 0, 0));
    push(vtx(0, -512, 100), vtx(0, 0, 100), vtx(0, 0, 100), 16'h00d5, 1, vtx(0, 0, 0));
    drain();

    // Random frames; later triangles carry a different cam_pos that must be ignored
    gap_pct = 25;
    for (int f = 0; f < 25; f++) begin
      int n;
      vertex_t fc;
      n  = 1 + int'($urandom_range(5));
      fc = rnd_cam();
      for (int k = 0; k < n; k++)
        push(rnd_v(), rnd_v(), rnd_v(), int'($urandom_range(65535)), k == n - 1,
             (k == 0) ? fc : rnd_cam());
    end
    drain();

    // Reset asserted in the middle of V2
    gap_pct = 0;
    push(vtx(7, 8, 90), vtx(9, 10, 91), vtx(11, 12, 92), 16'h00e1, 0, vtx(0, 0, 0));
    last_acc = -100;
    for (int g = 0; g < 100 && !(last_acc >= 0 && cyc == last_acc + 2); g++) step();
    check("reach_v2", 64'(cyc == last_acc + 2), 64'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_vertex", 64'(vertex), 64'(0));
    check("midrst_color", 64'(color), 64'(0));
    check("midrst_new", 64'(new_triangle_out), 64'(0));
    check("midrst_ready", 64'(tri_ready), 64'(0));
    exp_beat.delete();
    blocked.delete();
    in_frame   = 0;
    busy_until = 0;
    tri_valid  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_done", 64'(done_out), 64'(0));
    check("midrst_emitted", 64'(emitted_cnt), 64'(0));
    rst_n = 1'b1;

    // Next frame after the aborted one starts counting afresh
    push(vtx(1, 2, 40), vtx(3, 4, 41), vtx(5, 6, 42), 16'h00f1, 0, vtx(0, 0, 0));
    push(vtx(1, 2, 3), vtx(3, 4, 41), vtx(5, 6, 42), 16'h00f2, 0, vtx(0, 0, 0));
    push(vtx(-1, -2, 40), vtx(3, 4, 41), vtx(5, 6, 42), 16'h00f3, 1, vtx(0, 0, 0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
